// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: func3 encodings and FSM states.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    function automatic logic is_div_op(input logic [2:0] func3);
        return func3[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);

    logic             start_i;
    logic [2:0]       func3_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, func3_i, op_a_i, op_b_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, func3_i, op_a_i, op_b_i,
        output busy_o, valid_o, result_o
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and two's-complement result negation for signed RV32M ops.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         func3,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               res_neg,
    input  logic [2*WIDTH-1:0] raw,
    input  logic               neg_en,
    output logic [2*WIDTH-1:0] fixed
);

    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg = (func3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && op_a[WIDTH-1];
        b_neg = (func3 inside {F3_MULH, F3_DIV, F3_REM}) && op_b[WIDTH-1];
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;
        // Remainder follows the dividend; quotient and high products follow the sign product.
        unique case (func3)
            F3_MULH, F3_DIV:   res_neg = a_neg ^ b_neg;
            F3_MULHSU, F3_REM: res_neg = a_neg;
            default:           res_neg = 1'b0;
        endcase
        fixed = neg_en ? -raw : raw;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q;
    logic [2:0]         func3_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               res_neg;
    logic [2*WIDTH-1:0] raw;
    logic [2*WIDTH-1:0] fixed;

    logic [WIDTH-1:0]   int_min;
    logic               div_zero;
    logic               div_ovf;
    logic               take_special;
    logic [WIDTH-1:0]   spec_val;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   final_res;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .func3   (bus.func3_i),
        .op_a    (bus.op_a_i),
        .op_b    (bus.op_b_i),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .res_neg (res_neg),
        .raw     (raw),
        .neg_en  (neg_q),
        .fixed   (fixed)
    );

    always_comb begin
        int_min      = {1'b1, {(WIDTH-1){1'b0}}};
        div_zero     = (bus.op_b_i == '0);
        div_ovf      = (bus.func3_i == F3_DIV || bus.func3_i == F3_REM) &&
                       (bus.op_a_i == int_min) && (bus.op_b_i == '1);
        take_special = is_div_op(bus.func3_i) && (div_zero || div_ovf);
        if (div_zero)
            spec_val = bus.func3_i[1] ? bus.op_a_i : '1;
        else
            spec_val = bus.func3_i[1] ? '0 : int_min;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        // Partial remainder is WIDTH+1 bits once shifted; the difference fits WIDTH bits when kept.
        div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opd_q};
        div_diff = acc_q[2*WIDTH-2:WIDTH-1] - opd_q;
        div_next = {(div_ge ? div_diff : acc_q[2*WIDTH-2:WIDTH-1]), acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        if (!is_div_op(func3_q))
            raw = acc_q;
        else
            raw = {{WIDTH{1'b0}}, (func3_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0])};
        if (func3_q == F3_MUL || is_div_op(func3_q))
            final_res = fixed[WIDTH-1:0];
        else
            final_res = fixed[2*WIDTH-1:WIDTH];
    end

    // Special results are parked in both accumulator halves so DONE needs no separate path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            func3_q  <= '0;
            neg_q    <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        func3_q <= bus.func3_i;
                        cnt_q   <= '0;
                        if (take_special) begin
                            acc_q   <= {spec_val, spec_val};
                            neg_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, (is_div_op(bus.func3_i) ? mag_a : mag_b)};
                            opd_q   <= is_div_op(bus.func3_i) ? mag_b : mag_a;
                            neg_q   <= res_neg;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= is_div_op(func3_q) ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    valid_q  <= 1'b1;
                    result_q <= final_res;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state_q != ST_IDLE) || (bus.start_i && !rst);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a reference model, corner sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid result=%h expected=no_pulse", bus.result_o);
            end else begin
                check("result", bus.result_o, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        pu;
        logic signed [63:0] ps;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F3_MUL: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            F3_MULH: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
            F3_MULHSU: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return ps[63:32]; end
            F3_MULHU: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sr = sa / sb; return sr;
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                sr = sa % sb; return sr;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int n;
        bit busy_ok;
        bus.start_i = 1'b1;
        bus.func3_i = f;
        bus.op_a_i  = a;
        bus.op_b_i  = b;
        exp_q.push_back(exp);
        #1;
        check({name, "_busy_comb"}, 32'(bus.busy_o), 32'd1);
        busy_ok = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start_i = 1'b0;
                bus.func3_i = 3'($urandom);
                bus.op_a_i  = $urandom;
                bus.op_b_i  = $urandom;
            end
            #1;
            if (bus.valid_o) break;
            if (!bus.busy_o) busy_ok = 1'b0;
        end
        check({name, "_latency"}, 32'(n), 32'(lat));
        check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[23];
        vec_t bb[3];
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int n;
        int idx;
        bit busy_ok;

        vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14,        34};
        vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2,         34};
        vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[9]  = '{F3_REM,    32'd5,         32'd0,         32'd5,         2};
        vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[12] = '{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[13] = '{F3_REMU,   32'd5,         32'd0,         32'd5,         2};
        vecs[14] = '{F3_MUL,    32'h1234_5678, 32'd9,         32'hA3D7_0A38, 34};
        vecs[15] = '{F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[16] = '{F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34};
        vecs[17] = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[18] = '{F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34};
        vecs[19] = '{F3_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[20] = '{F3_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 34};
        vecs[21] = '{F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[22] = '{F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         34};

        bb[0] = '{F3_DIVU, 32'd100,       32'd7,         32'd14,        34};
        bb[1] = '{F3_REM,  32'd5,         32'd0,         32'd5,         2};
        bb[2] = '{F3_MUL,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};

        // Reset held while start_i is high: reset must win every edge.
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.func3_i = F3_MUL;
        bus.op_a_i  = 32'd3;
        bus.op_b_i  = 32'd4;
        repeat (3) @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_busy",   32'(bus.busy_o),  32'd0);
        check("reset_valid",  32'(bus.valid_o), 32'd0);
        check("reset_result", bus.result_o,     32'd0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 23; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 6 == 5) ? 32'd0 : $urandom;
            if (i % 8 == 3) b = b & 32'h0000_00FF;
            run_op(f, a, b, model(f, a, b), (f[2] && b == 0) ? 2 : 34, $sformatf("rand%0d", i));
        end

        // start_i pulsed mid-CALC with different operands must be ignored.
        bus.start_i = 1'b1;
        bus.func3_i = F3_MUL;
        bus.op_a_i  = 32'h10;
        bus.op_b_i  = 32'h20;
        exp_q.push_back(32'h200);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start_i = 1'b0;
            if (n == 10) begin
                bus.start_i = 1'b1;
                bus.func3_i = F3_DIVU;
                bus.op_a_i  = 32'd9;
                bus.op_b_i  = 32'd0;
            end
            if (n == 11) bus.start_i = 1'b0;
            #1;
            if (bus.valid_o) break;
        end
        check("midstart_latency", 32'(n), 32'd34);
        repeat (40) @(negedge clk);

        // Reset during CALC aborts with no result pulse.
        #1;
        bus.start_i = 1'b1;
        bus.func3_i = F3_DIV;
        bus.op_a_i  = 32'd100;
        bus.op_b_i  = 32'd7;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) bus.start_i = 1'b0;
            if (k == 10) rst = 1'b1;
            if (k == 11) begin
                #1;
                check("abort_busy",   32'(bus.busy_o),  32'd0);
                check("abort_valid",  32'(bus.valid_o), 32'd0);
                check("abort_result", bus.result_o,     32'd0);
                rst = 1'b0;
            end
        end
        repeat (40) @(negedge clk);

        // start_i held high: each op accepted in the IDLE cycle that shows the previous result.
        #1;
        bus.start_i = 1'b1;
        bus.func3_i = bb[0].f;
        bus.op_a_i  = bb[0].a;
        bus.op_b_i  = bb[0].b;
        exp_q.push_back(bb[0].exp);
        n = 0;
        idx = 0;
        busy_ok = 1'b1;
        while (idx < 3 && n < 200) begin
            @(negedge clk);
            n++;
            #1;
            if (bus.valid_o) begin
                check($sformatf("b2b%0d_gap", idx), 32'(n), 32'(bb[idx].lat));
                idx++;
                n = 0;
                if (idx < 3) begin
                    bus.func3_i = bb[idx].f;
                    bus.op_a_i  = bb[idx].a;
                    bus.op_b_i  = bb[idx].b;
                    exp_q.push_back(bb[idx].exp);
                end else begin
                    bus.start_i = 1'b0;
                end
            end else if (!bus.busy_o) begin
                busy_ok = 1'b0;
            end
        end
        check("b2b_ops_done", 32'(idx), 32'd3);
        check("b2b_busy_held", 32'(busy_ok), 32'd1);
        bus.start_i = 1'b0;
        repeat (40) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
